// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM chip emulator: command encodings,
// mode-register fields, per-bank state and read-pipeline slot layout.
package sdram_pkg;

  // {nRAS, nCAS, nWE}, same encodings as the sdram controller
  localparam logic [2:0] CMD_LOAD_MODE    = 3'b000;
  localparam logic [2:0] CMD_AUTO_REFRESH = 3'b001;
  localparam logic [2:0] CMD_PRECHARGE    = 3'b010;
  localparam logic [2:0] CMD_ACTIVE       = 3'b011;
  localparam logic [2:0] CMD_WRITE        = 3'b100;
  localparam logic [2:0] CMD_READ         = 3'b101;
  localparam logic [2:0] CMD_BURST_TERM   = 3'b110;
  localparam logic [2:0] CMD_NOP          = 3'b111;

  // Mode-register fields on A[]
  localparam int unsigned MODE_CL_LSB = 4;
  localparam int unsigned MODE_CL_MSB = 6;
  localparam int unsigned MODE_BL_MSB = 2;
  // A10: auto-precharge on READ/WRITE, all-banks on PRECHARGE
  localparam int unsigned AP_BIT      = 10;

  localparam int unsigned ROW_BITS  = 13;
  localparam int unsigned COL_BITS  = 9;
  localparam int unsigned AGE_BITS  = 4;
  localparam int unsigned NUM_BANKS = 4;

  typedef struct packed {
    logic                open;
    logic [ROW_BITS-1:0] row;
    logic [AGE_BITS-1:0] age;
  } bank_t;

  typedef struct packed {
    logic       valid;
    logic       cl3;
    logic [1:0] mask;   // {upper, lower}, 1 = byte masked
  } rd_slot_t;

  // Masked bytes read back as zero
  function automatic logic [15:0] mask_bytes(input logic [15:0] d, input logic [1:0] m);
    return {m[1] ? 8'h00 : d[15:8], m[0] ? 8'h00 : d[7:0]};
  endfunction

endpackage

// File: rtl/sdram_emu_mem.sv
// Single-port byte-enabled 16-bit block RAM with a registered read port.
module sdram_emu_mem
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we,
  input  logic [1:0]           be,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem_q [2**ADDR_BITS];

  // Byte-lane writes and a 1-cycle registered read
  always_ff @(posedge clk) begin
    if (we && be[0]) mem_q[addr][7:0] <= wdata[7:0];
    if (we && be[1]) mem_q[addr][15:8] <= wdata[15:8];
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/sdram_chip_emu.sv
// Synthesizable stand-in for a 16-bit SDR SDRAM chip on the controller pins.
// Define SDRAM_EMU_TIMING_CHECK_EN to build in the tRCD, refresh-with-open-bank
// and load-mode-with-open-bank checks (and the per-bank age counters).
module sdram_chip_emu
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned TRCD      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cke,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        protocol_err,
  output logic [15:0] refresh_cnt
);

  localparam logic [AGE_BITS-1:0] AgeSat = AGE_BITS'(TRCD);
`ifdef SDRAM_EMU_TIMING_CHECK_EN
  localparam logic [AGE_BITS-1:0] ActAge = '0;
`else
  // Without the checks the age is pinned saturated so tRCD never trips
  localparam logic [AGE_BITS-1:0] ActAge = AgeSat;
`endif

  bank_t          bank_q [NUM_BANKS];
  bank_t          bank_d [NUM_BANKS];
  bank_t          cur;
  logic           cl3_q, cl3_d;
  logic           err_q, err_d;
  logic [15:0]    ref_q, ref_d;
  rd_slot_t       slot_q [3];
  rd_slot_t       slot0_d;
  logic [15:0]    data1_q, data2_q;
  logic [15:0]    dq_out_q, dq_out_d;
  logic           dq_oe_q, dq_oe_d;
  logic [2:0]     cmd;
  logic [2:0]     mode_cl;
  logic           open_viol;
  logic           trcd_short;
  logic           cancel, rd_issue, mem_we;
  logic [15:0]    mem_rdata;
  logic [ADDR_BITS-1:0] mem_addr;

  assign cmd        = (sd_ncs || !sd_cke) ? CMD_NOP : {sd_nras, sd_ncas, sd_nwe};
  assign cur        = bank_q[sd_ba];
  assign mode_cl    = sd_a[MODE_CL_MSB:MODE_CL_LSB];
  assign mem_addr   = ADDR_BITS'({sd_ba, cur.row, sd_a[COL_BITS-1:0]});
  // Age reads 0 in the cycle after ACTIVE, so distance is age + 1
  assign trcd_short = (32'(cur.age) + 32'd1) < TRCD;

`ifdef SDRAM_EMU_TIMING_CHECK_EN
  assign open_viol = bank_q[0].open | bank_q[1].open | bank_q[2].open | bank_q[3].open;
`else
  assign open_viol = 1'b0;
`endif

  // Command decode: bank state, mode register, refresh count, error flag
  always_comb begin
    bank_d   = bank_q;
    cl3_d    = cl3_q;
    err_d    = err_q;
    ref_d    = ref_q;
    cancel   = 1'b0;
    rd_issue = 1'b0;
    mem_we   = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
`ifdef SDRAM_EMU_TIMING_CHECK_EN
      if (bank_q[b].age < AgeSat) bank_d[b].age = bank_q[b].age + 1'b1;
`else
      bank_d[b].age = AgeSat;
`endif
    end
    case (cmd)
      CMD_LOAD_MODE: begin
        if (open_viol) begin
          err_d = 1'b1;
        end else begin
          if (mode_cl == 3'd2 || mode_cl == 3'd3) cl3_d = mode_cl[0];
          else                                    err_d = 1'b1;
          if (sd_a[MODE_BL_MSB:0] != '0) err_d = 1'b1;
        end
      end
      CMD_ACTIVE: begin
        if (cur.open) err_d = 1'b1;
        bank_d[sd_ba].open = 1'b1;
        bank_d[sd_ba].row  = sd_a;
        bank_d[sd_ba].age  = ActAge;
      end
      CMD_READ, CMD_WRITE: begin
        if (!cur.open) begin
          err_d = 1'b1;
        end else begin
          if (trcd_short) err_d = 1'b1;
          if (sd_a[AP_BIT]) bank_d[sd_ba].open = 1'b0;
          if (cmd == CMD_WRITE) begin
            mem_we = 1'b1;
            cancel = 1'b1;
          end else begin
            rd_issue = 1'b1;
          end
        end
      end
      CMD_PRECHARGE: begin
        if (sd_a[AP_BIT]) begin
          for (int b = 0; b < NUM_BANKS; b++) bank_d[b].open = 1'b0;
        end else begin
          bank_d[sd_ba].open = 1'b0;
        end
      end
      CMD_AUTO_REFRESH: begin
        ref_d = ref_q + 16'd1;
        if (open_viol) err_d = 1'b1;
      end
      CMD_BURST_TERM: cancel = 1'b1;
      default: ;
    endcase
  end

  // Read pipeline head and output selection by the latency each read carries
  always_comb begin
    slot0_d  = rd_issue ? '{valid: 1'b1, cl3: cl3_q, mask: {sd_dqmh, sd_dqml}} : '0;
    dq_oe_d  = 1'b0;
    dq_out_d = '0;
    if (!cancel) begin
      if (slot_q[2].valid && slot_q[2].cl3) begin
        dq_oe_d  = 1'b1;
        dq_out_d = mask_bytes(data2_q, slot_q[2].mask);
      end else if (slot_q[1].valid && !slot_q[1].cl3) begin
        dq_oe_d  = 1'b1;
        dq_out_d = mask_bytes(data1_q, slot_q[1].mask);
      end
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= '{open: 1'b0, row: '0, age: AgeSat};
      cl3_q    <= 1'b0;
      err_q    <= 1'b0;
      ref_q    <= '0;
      for (int s = 0; s < 3; s++) slot_q[s] <= '0;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      bank_q    <= bank_d;
      cl3_q     <= cl3_d;
      err_q     <= err_d;
      ref_q     <= ref_d;
      slot_q[0] <= slot0_d;
      slot_q[1] <= cancel ? '0 : slot_q[0];
      slot_q[2] <= cancel ? '0 : slot_q[1];
      dq_oe_q   <= dq_oe_d;
      dq_out_q  <= dq_out_d;
    end
  end

  // Data follows the BRAM output; validity is tracked by the slots
  always_ff @(posedge clk) begin
    data1_q <= mem_rdata;
    data2_q <= data1_q;
  end

  sdram_emu_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk  (clk),
    .addr (mem_addr),
    .we   (mem_we),
    .be   (~{sd_dqmh, sd_dqml}),
    .wdata(dq_in),
    .rdata(mem_rdata)
  );

  assign dq_out       = dq_out_q;
  assign dq_oe        = dq_oe_q;
  assign protocol_err = err_q;
  assign refresh_cnt  = ref_q;

endmodule

// File: tb/tb_sdram_chip_emu.sv
// Scoreboard bench for sdram_chip_emu: directed test-plan sequences followed by
// randomized command streams, checked against a transaction-level chip model.
module tb_sdram_chip_emu;

  localparam int unsigned ABITS = 14;
  localparam int unsigned TRCD  = 2;
  localparam logic [2:0] C_LM = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_BT = 3'b110, C_NOP = 3'b111;
`ifdef SDRAM_EMU_TIMING_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        sd_cke = 1'b1, sd_ncs = 1'b1, sd_nras = 1'b1, sd_ncas = 1'b1, sd_nwe = 1'b1;
  logic [1:0]  sd_ba = '0;
  logic [12:0] sd_a = '0;
  logic        sd_dqml = 1'b0, sd_dqmh = 1'b0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out, refresh_cnt;
  logic        dq_oe, protocol_err;

  sdram_chip_emu #(.ADDR_BITS(ABITS), .TRCD(TRCD)) dut (
    .clk(clk), .reset(reset), .sd_cke(sd_cke), .sd_ncs(sd_ncs), .sd_nras(sd_nras),
    .sd_ncas(sd_ncas), .sd_nwe(sd_nwe), .sd_ba(sd_ba), .sd_a(sd_a), .sd_dqml(sd_dqml),
    .sd_dqmh(sd_dqmh), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .protocol_err(protocol_err), .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] care;
  } exp_t;
  exp_t        expq[$];
  bit          m_open[4];
  logic [12:0] m_row[4];
  int          m_act[4];
  int          m_cl;
  bit          m_err;
  logic [15:0] m_ref;
  logic [15:0] m_mem[int];
  logic [1:0]  m_known[int];

  int cyc = 0, vectors = 0, miscompares = 0;
  bit chk_en = 0, after_rst = 0;

  task automatic cancel_from(input int e);
    for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].due >= e) expq.delete(i);
  endtask

  // Effect of a command taking place at clock edge n
  task automatic model(input logic [2:0] cmd, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] d, input int n);
    bit          any_open;
    logic [23:0] full;
    int          addr;
    logic [15:0] v, care;
    logic [1:0]  kn;
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    case (cmd)
      C_LM: begin
        if (CHK && any_open) m_err = 1;
        else begin
          if (a[6:4] == 3'd2 || a[6:4] == 3'd3) m_cl = int'(a[6:4]);
          else m_err = 1;
          if (a[2:0] != 3'd0) m_err = 1;
        end
      end
      C_ACT: begin
        if (m_open[ba]) m_err = 1;
        m_open[ba] = 1; m_row[ba] = a; m_act[ba] = n;
      end
      C_RD, C_WR: begin
        if (!m_open[ba]) m_err = 1;
        else begin
          if (CHK && (n - m_act[ba]) < int'(TRCD)) m_err = 1;
          full = {ba, m_row[ba], a[8:0]};
          addr = int'(full) % (1 << ABITS);
          v  = m_mem.exists(addr) ? m_mem[addr] : 16'h0;
          kn = m_known.exists(addr) ? m_known[addr] : 2'b00;
          if (cmd == C_WR) begin
            if (!a[12]) begin v[15:8] = d[15:8]; kn[1] = 1'b1; end
            if (!a[11]) begin v[7:0] = d[7:0]; kn[0] = 1'b1; end
            m_mem[addr] = v; m_known[addr] = kn;
            cancel_from(n);
          end else begin
            care = {{8{kn[1]}}, {8{kn[0]}}};
            if (a[12]) begin v[15:8] = 8'h00; care[15:8] = 8'hFF; end
            if (a[11]) begin v[7:0] = 8'h00; care[7:0] = 8'hFF; end
            expq.push_back('{due: n + m_cl, data: v, care: care});
          end
          if (a[10]) m_open[ba] = 0;
        end
      end
      C_PRE: begin
        if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 0;
        else m_open[ba] = 0;
      end
      C_REF: begin
        m_ref = m_ref + 16'd1;
        if (CHK && any_open) m_err = 1;
      end
      C_BT: cancel_from(n);
      default: ;
    endcase
  endtask

  // gate: 0 normal, 1 chip-select high, 2 clock-enable low
  task automatic issue(input logic [2:0] cmd, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] d, input int gate);
    @(negedge clk);
    reset = 1'b0;
    sd_ncs = (gate == 1); sd_cke = (gate != 2);
    {sd_nras, sd_ncas, sd_nwe} = cmd;
    sd_ba = ba; sd_a = a; sd_dqmh = a[12]; sd_dqml = a[11]; dq_in = d;
    model((gate != 0) ? C_NOP : cmd, ba, a, d, cyc + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sd_ncs = 1'b1; {sd_nras, sd_ncas, sd_nwe} = C_NOP;
    for (int b = 0; b < 4; b++) m_open[b] = 0;
    m_cl = 2; m_err = 0; m_ref = '0;
    expq.delete();
    after_rst = 1; chk_en = 1;
  endtask

  task automatic nop(input int k);
    for (int i = 0; i < k; i++) issue(C_NOP, 2'd0, 13'd0, 16'd0, 0);
  endtask
  task automatic act(input logic [1:0] ba, input logic [12:0] row);
    issue(C_ACT, ba, row, 16'd0, 0);
  endtask
  task automatic wr(input logic [1:0] ba, input logic [8:0] col, input logic [15:0] d,
                    input bit mh, input bit ml, input bit ap);
    issue(C_WR, ba, {mh, ml, ap, 1'b0, col}, d, 0);
  endtask
  task automatic rd(input logic [1:0] ba, input logic [8:0] col, input bit mh, input bit ml,
                    input bit ap);
    issue(C_RD, ba, {mh, ml, ap, 1'b0, col}, 16'd0, 0);
  endtask

  // Monitor: compares flags every cycle and pops the scoreboard on each dq_oe
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (chk_en) begin
        if (after_rst) begin
          vectors++;
          if (dq_out !== 16'h0 || dq_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: dq_out=%h dq_oe=%b, want 0000/0", dq_out, dq_oe);
          end
          after_rst = 0;
        end
        vectors++;
        if (protocol_err !== m_err) begin
          miscompares++;
          $display("FAIL protocol_err @%0d: got %b want %b", cyc, protocol_err, m_err);
        end
        vectors++;
        if (refresh_cnt !== m_ref) begin
          miscompares++;
          $display("FAIL refresh_cnt @%0d: got %h want %h", cyc, refresh_cnt, m_ref);
        end
        while (expq.size() > 0 && expq[0].due < cyc) begin
          vectors++; miscompares++;
          $display("FAIL read_missing: no dq_oe at cycle %0d, want data %h", expq[0].due,
                   expq[0].data);
          void'(expq.pop_front());
        end
        if (dq_oe !== 1'b0) begin
          vectors++;
          if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL read_unexpected @%0d: dq_oe=%b dq_out=%h, want no read", cyc, dq_oe,
                     dq_out);
          end else begin
            e = expq.pop_front();
            if (e.due != cyc || ((dq_out ^ e.data) & e.care) != 16'h0 || dq_oe !== 1'b1) begin
              miscompares++;
              $display("FAIL read_data @%0d: got %h want %h (care %h) due %0d", cyc, dq_out,
                       e.data, e.care, e.due);
            end
          end
        end
      end
    end
  end

  initial begin
    int unsigned sel;
    logic [1:0]  ba;
    logic [2:0]  clr, bl;
    int          gate;
    logic [2:0]  rcmd;

    nop(2);
    do_reset();
    nop(2);
    // Basic write/read at CL2
    issue(C_LM, 2'd0, 13'h0220, 16'd0, 0);
    act(2'd1, 13'h0123);
    nop(1);
    wr(2'd1, 9'h005, 16'hBEEF, 0, 0, 0);
    rd(2'd1, 9'h005, 0, 0, 0);
    nop(4);
    // Byte masks
    wr(2'd1, 9'h006, 16'hAAAA, 0, 0, 0);
    wr(2'd1, 9'h006, 16'h1234, 1, 0, 0);
    rd(2'd1, 9'h006, 0, 0, 0);
    nop(1);
    rd(2'd1, 9'h006, 0, 1, 0);
    nop(4);
    // CL3 back-to-back
    issue(C_PRE, 2'd0, 13'h0400, 16'd0, 0);
    issue(C_LM, 2'd0, 13'h0230, 16'd0, 0);
    act(2'd1, 13'h0123);
    nop(1);
    wr(2'd1, 9'h000, 16'h0001, 0, 0, 0);
    wr(2'd1, 9'h001, 16'h0002, 0, 0, 0);
    rd(2'd1, 9'h000, 0, 0, 0);
    rd(2'd1, 9'h001, 0, 0, 0);
    nop(5);
    // Protocol violations
    do_reset();
    rd(2'd2, 9'h000, 0, 0, 0);
    nop(4);
    do_reset();
    act(2'd0, 13'h0001);
    nop(2);
    issue(C_REF, 2'd0, 13'd0, 16'd0, 0);
    nop(2);
    // tRCD and auto-precharge
    do_reset();
    act(2'd0, 13'h0123);
    rd(2'd0, 9'h005, 0, 0, 0);
    nop(4);
    do_reset();
    act(2'd1, 13'h0123);
    nop(2);
    rd(2'd1, 9'h005, 0, 0, 1);
    nop(1);
    rd(2'd1, 9'h005, 0, 0, 0);
    nop(4);
    // Reset mid-read
    do_reset();
    issue(C_LM, 2'd0, 13'h0230, 16'd0, 0);
    act(2'd1, 13'h0123);
    nop(2);
    rd(2'd1, 9'h005, 0, 0, 0);
    do_reset();
    nop(5);
    act(2'd1, 13'h0123);
    nop(2);
    rd(2'd1, 9'h005, 0, 0, 0);
    nop(4);

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int k = 0; k < 60; k++) begin
        sel  = $urandom_range(0, 99);
        ba   = 2'($urandom_range(0, 1));
        gate = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0;
        if (sel < 15) begin
          issue(C_ACT, ba, 13'($urandom_range(0, 3)), 16'd0, gate);
        end else if (sel < 75) begin
          rcmd = (sel < 45) ? C_WR : C_RD;
          issue(rcmd, ba, {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 7) == 0), 1'b0, 9'($urandom_range(0, 7))},
                16'($urandom), gate);
        end else if (sel < 83) begin
          issue(C_PRE, ba, {2'b00, ($urandom_range(0, 1) == 1), 10'd0}, 16'd0, gate);
        end else if (sel < 88) begin
          issue(C_REF, ba, 13'd0, 16'd0, gate);
        end else if (sel < 92) begin
          clr = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
              : (($urandom_range(0, 1) == 1) ? 3'd3 : 3'd2);
          bl  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
          issue(C_LM, 2'd0, {6'd0, clr, 1'b0, bl}, 16'd0, gate);
        end else if (sel < 94) begin
          issue(C_BT, ba, 13'd0, 16'd0, gate);
        end else begin
          issue(C_NOP, ba, 13'd0, 16'd0, gate);
        end
      end
      nop(5);
    end

    nop(6);
    @(negedge clk);
    chk_en = 0;
    while (expq.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL read_pending: read due at %0d never presented, want %h", expq[0].due,
               expq[0].data);
      void'(expq.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
